// File: rtl/mips_pkg.sv
// Shared definitions for the fetch stage: reset PC default, fetch FSM
// states, instruction stride and a sequential-PC helper.
package mips_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] INSTR_STRIDE     = 32'd4;

    typedef enum logic [1:0] {
        BOOT      = 2'd0,
        RUN       = 2'd1,
        SLOT_WAIT = 2'd2
    } fetchState_t;

    // Sequential successor of a fetch address; wraps modulo 2^32.
    function automatic logic [31:0] nextSeqPc(input logic [31:0] pc);
        return pc + INSTR_STRIDE;
    endfunction

endpackage

// File: rtl/fetch_stage_ifid.sv
// IF/ID pipeline register. Stall holds every field. Otherwise a completed,
// un-flushed fetch loads a valid instruction, and anything else loads a
// bubble that still carries PC+4.
module ifid_reg
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    input  logic        load,
    input  logic [31:0] fetchInstr,
    input  logic [31:0] fetchPcPlus4,
    output logic [31:0] instrD,
    output logic [31:0] pcPlus4D,
    output logic        validD
);

    // Register update: hold on stall, otherwise take an instruction or a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instrD   <= 32'h0;
            pcPlus4D <= 32'h0;
            validD   <= 1'b0;
        end else if (!stall) begin
            if (load && !flush) begin
                instrD   <= fetchInstr;
                pcPlus4D <= fetchPcPlus4;
                validD   <= 1'b1;
            end else begin
                instrD   <= 32'h0;
                pcPlus4D <= fetchPcPlus4;
                validD   <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, fetch FSM and the IF/ID register.
// Define BRANCH_DELAY_SLOT_EN to execute the instruction after a taken
// branch/jump (delay slot); without it the wrong-path fetch is flushed.
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] PCF,
    output logic        ImemReqF,
    input  logic        ImemAckF,
    input  logic [31:0] InstrF,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        BranchD,
    input  logic        ConditionD,
    input  logic [31:0] PCBranchD,
    input  logic        JumpD,
    input  logic [31:0] PCJumpD,
    output logic [31:0] InstrD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD
);

    fetchState_t state;
    fetchState_t stateNext;
    logic [31:0] pcNext;
    logic [31:0] pcPlus4F;
    logic [31:0] redirectTarget;
    logic        fetchDone;
    logic        redirectD;
    logic        flushD;
`ifdef BRANCH_DELAY_SLOT_EN
    logic [31:0] pendingPc;
    logic [31:0] pendingNext;
`endif

    assign ImemReqF       = (state != BOOT);
    assign fetchDone      = ImemReqF && ImemAckF && !StallF;
    assign redirectD      = ((BranchD && ConditionD) || JumpD) && !StallD;
    assign redirectTarget = JumpD ? PCJumpD : PCBranchD;
    assign pcPlus4F       = nextSeqPc(PCF);

    // Next-state, next-PC and flush decisions for the fetch FSM.
    always_comb begin
        stateNext = state;
        pcNext    = PCF;
        flushD    = 1'b0;
`ifdef BRANCH_DELAY_SLOT_EN
        pendingNext = pendingPc;
`endif
        case (state)
            BOOT: begin
                stateNext = RUN;
            end
            RUN: begin
`ifdef BRANCH_DELAY_SLOT_EN
                if (redirectD) begin
                    if (fetchDone) begin
                        pcNext = redirectTarget;
                    end else begin
                        pendingNext = redirectTarget;
                        stateNext   = SLOT_WAIT;
                    end
                end else if (fetchDone) begin
                    pcNext = pcPlus4F;
                end
`else
                if (redirectD) begin
                    pcNext = redirectTarget;
                    flushD = 1'b1;
                end else if (fetchDone) begin
                    pcNext = pcPlus4F;
                end
`endif
            end
            SLOT_WAIT: begin
`ifdef BRANCH_DELAY_SLOT_EN
                if (fetchDone) begin
                    pcNext    = pendingPc;
                    stateNext = RUN;
                end
`else
                stateNext = RUN;
`endif
            end
            default: begin
                stateNext = BOOT;
            end
        endcase
    end

    // State and PC registers; reset drops any pending redirect target.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= BOOT;
            PCF   <= RESET_PC;
`ifdef BRANCH_DELAY_SLOT_EN
            pendingPc <= RESET_PC;
`endif
        end else begin
            state <= stateNext;
            PCF   <= pcNext;
`ifdef BRANCH_DELAY_SLOT_EN
            pendingPc <= pendingNext;
`endif
        end
    end

    ifid_reg uIfid (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (StallD),
        .flush        (flushD),
        .load         (fetchDone),
        .fetchInstr   (InstrF),
        .fetchPcPlus4 (pcPlus4F),
        .instrD       (InstrD),
        .pcPlus4D     (PCPlus4D),
        .validD       (ValidD)
    );

endmodule
